// File: rtl/conv3x3_engine_top.sv
// 3x3 valid cross-correlation of a 4x4 matrix, computed by a single-MAC engine,
// a 3-PE systolic line and a 2-PE systolic pair, then streamed out one result per cycle.
module conv3x3_engine_top #(
    parameter int DW   = 8,
    parameter int ACCW = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [DW-1:0] a11, a12, a13, a14,
    input  logic [DW-1:0] a21, a22, a23, a24,
    input  logic [DW-1:0] a31, a32, a33, a34,
    input  logic [DW-1:0] a41, a42, a43, a44,
    input  logic [DW-1:0] b11, b12, b13,
    input  logic [DW-1:0] b21, b22, b23,
    input  logic [DW-1:0] b31, b32, b33,
    output logic [DW-1:0] display_result,
    output logic [2:0]    display_current_state
);
    localparam int PW = 2 * DW;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SINGLE  = 3'd1,
        S_SYS3    = 3'd2,
        S_SYS2    = 3'd3,
        S_DISPLAY = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    function automatic logic [ACCW-1:0] mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [PW-1:0] p;
        p = PW'(x) * PW'(y);
        return ACCW'(p);
    endfunction

    logic [DW-1:0]   a_in [4][4];
    logic [DW-1:0]   b_in [3][3];
    logic [DW-1:0]   a_q  [4][4];
    logic [DW-1:0]   b_q  [3][3];
    logic [ACCW-1:0] res  [12];

    state_t     state, state_next;
    logic [6:0] cnt;
    logic       start;

    assign a_in[0] = '{a11, a12, a13, a14};
    assign a_in[1] = '{a21, a22, a23, a24};
    assign a_in[2] = '{a31, a32, a33, a34};
    assign a_in[3] = '{a41, a42, a43, a44};
    assign b_in[0] = '{b11, b12, b13};
    assign b_in[1] = '{b21, b22, b23};
    assign b_in[2] = '{b31, b32, b33};

    assign start = (state == S_IDLE) && run;
    assign display_current_state = state;

    // ---------------- control FSM and fixed schedule ----------------
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            S_IDLE:    if (run)            state_next = S_SINGLE;
            S_SINGLE:  if (cnt == 7'd39)   state_next = S_SYS3;
            S_SYS3:    if (cnt == 7'd59)   state_next = S_SYS2;
            S_SYS2:    if (cnt == 7'd86)   state_next = S_DISPLAY;
            S_DISPLAY: if (cnt == 7'd98)   state_next = S_DONE;
            S_DONE:    if (!run)           state_next = S_IDLE;
            default:                       state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset)                                   cnt <= '0;
        else if (start)                              cnt <= '0;
        else if (state != S_IDLE && state != S_DONE) cnt <= cnt + 7'd1;
    end

    // NOTE: operand registers need no reset; they are only read after a start loads them.
    always_ff @(posedge clk) begin
        if (start) begin
            a_q <= a_in;
            b_q <= b_in;
        end
    end

    // ---------------- single-MAC engine: 9 MACs per output ----------------
    logic            sg_busy;
    logic [1:0]      sg_n, sg_k, sg_l, sg_row, sg_col;
    logic [ACCW-1:0] sg_acc, sg_sum;

    always_comb begin
        sg_row = {1'b0, sg_n[1]} + sg_k;
        sg_col = {1'b0, sg_n[0]} + sg_l;
        sg_sum = ((sg_k == 2'd0 && sg_l == 2'd0) ? '0 : sg_acc)
               + mul(a_q[sg_row][sg_col], b_q[sg_k][sg_l]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sg_busy <= 1'b0;
            sg_n    <= '0;
            sg_k    <= '0;
            sg_l    <= '0;
            sg_acc  <= '0;
        end else if (start) begin
            sg_busy <= 1'b1;
            sg_n    <= '0;
            sg_k    <= '0;
            sg_l    <= '0;
        end else if (sg_busy) begin
            sg_acc <= sg_sum;
            if (sg_l == 2'd2) begin
                sg_l <= '0;
                if (sg_k == 2'd2) begin
                    sg_k <= '0;
                    sg_n <= sg_n + 2'd1;
                    if (sg_n == 2'd3) sg_busy <= 1'b0;
                end else begin
                    sg_k <= sg_k + 2'd1;
                end
            end else begin
                sg_l <= sg_l + 2'd1;
            end
        end
    end

    // ---------------- 3-PE systolic line, PE k owns kernel row k ----------------
    // Each PE starts one cycle after its upstream neighbour, so the upstream partial
    // sum for an output lands exactly on the downstream PE's last MAC of that output.
    logic            s3_busy [3];
    logic [1:0]      s3_n    [3];
    logic [1:0]      s3_l    [3];
    logic [1:0]      s3_row  [3];
    logic [1:0]      s3_col  [3];
    logic [ACCW-1:0] s3_acc  [3];
    logic [ACCW-1:0] s3_sum  [3];
    logic [ACCW-1:0] s3_fwd  [3];
    logic [ACCW-1:0] s3_psum [2];
    logic            s3_start;

    assign s3_start = (state == S_SINGLE) && (cnt == 7'd39);

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            s3_row[k] = {1'b0, s3_n[k][1]} + 2'(k);
            s3_col[k] = {1'b0, s3_n[k][0]} + s3_l[k];
            s3_sum[k] = ((s3_l[k] == 2'd0) ? '0 : s3_acc[k])
                      + mul(a_q[s3_row[k]][s3_col[k]], b_q[k][s3_l[k]]);
        end
        s3_fwd[0] = s3_sum[0];
        s3_fwd[1] = s3_sum[1] + s3_psum[0];
        s3_fwd[2] = s3_sum[2] + s3_psum[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                s3_busy[k] <= 1'b0;
                s3_n[k]    <= '0;
                s3_l[k]    <= '0;
                s3_acc[k]  <= '0;
            end
            s3_psum[0] <= '0;
            s3_psum[1] <= '0;
        end else if (s3_start) begin
            for (int k = 0; k < 3; k++) begin
                s3_busy[k] <= (k == 0);
                s3_n[k]    <= '0;
                s3_l[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (s3_busy[k]) begin
                    s3_acc[k] <= s3_sum[k];
                    if (s3_l[k] == 2'd2) begin
                        s3_l[k] <= '0;
                        s3_n[k] <= s3_n[k] + 2'd1;
                        if (k < 2) s3_psum[k] <= s3_fwd[k];
                        if (s3_n[k] == 2'd3) s3_busy[k] <= 1'b0;
                    end else begin
                        s3_l[k] <= s3_l[k] + 2'd1;
                    end
                end
            end
            if (s3_busy[0] && s3_n[0] == 2'd0 && s3_l[0] == 2'd0) s3_busy[1] <= 1'b1;
            if (s3_busy[1] && s3_n[1] == 2'd0 && s3_l[1] == 2'd0) s3_busy[2] <= 1'b1;
        end
    end

    // ---------------- 2-PE engine: PE0 even terms, PE1 odd terms ----------------
    function automatic logic [3:0] term_kl(input logic [3:0] t);
        unique case (t)
            4'd0:    return {2'd0, 2'd0};
            4'd1:    return {2'd0, 2'd1};
            4'd2:    return {2'd0, 2'd2};
            4'd3:    return {2'd1, 2'd0};
            4'd4:    return {2'd1, 2'd1};
            4'd5:    return {2'd1, 2'd2};
            4'd6:    return {2'd2, 2'd0};
            4'd7:    return {2'd2, 2'd1};
            default: return {2'd2, 2'd2};
        endcase
    endfunction

    logic            s2_busy, s2_start;
    logic [1:0]      s2_n;
    logic [2:0]      s2_s;
    logic [3:0]      s2_kl0, s2_kl1;
    logic [1:0]      s2_r0, s2_c0, s2_r1, s2_c1;
    logic [ACCW-1:0] s2_acc0, s2_acc1, s2_sum0, s2_sum1;

    assign s2_start = (state == S_SYS3) && (cnt == 7'd59);

    always_comb begin
        s2_kl0  = term_kl({s2_s, 1'b0});
        s2_kl1  = (s2_s == 3'd4) ? 4'd0 : term_kl({s2_s, 1'b1});
        s2_r0   = {1'b0, s2_n[1]} + s2_kl0[3:2];
        s2_c0   = {1'b0, s2_n[0]} + s2_kl0[1:0];
        s2_r1   = {1'b0, s2_n[1]} + s2_kl1[3:2];
        s2_c1   = {1'b0, s2_n[0]} + s2_kl1[1:0];
        s2_sum0 = ((s2_s == 3'd0) ? '0 : s2_acc0)
                + mul(a_q[s2_r0][s2_c0], b_q[s2_kl0[3:2]][s2_kl0[1:0]]);
        s2_sum1 = ((s2_s == 3'd0) ? '0 : s2_acc1)
                + mul(a_q[s2_r1][s2_c1], b_q[s2_kl1[3:2]][s2_kl1[1:0]]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_busy <= 1'b0;
            s2_n    <= '0;
            s2_s    <= '0;
            s2_acc0 <= '0;
            s2_acc1 <= '0;
        end else if (s2_start) begin
            s2_busy <= 1'b1;
            s2_n    <= '0;
            s2_s    <= '0;
        end else if (s2_busy) begin
            s2_acc0 <= s2_sum0;
            if (s2_s == 3'd4) begin
                s2_s <= '0;
                s2_n <= s2_n + 2'd1;
                if (s2_n == 2'd3) s2_busy <= 1'b0;
            end else begin
                s2_acc1 <= s2_sum1;
                s2_s    <= s2_s + 3'd1;
            end
        end
    end

    // ---------------- result bank and display stream ----------------
    logic       disp_load;
    logic [3:0] disp_idx;

    assign disp_idx  = 4'(cnt - 7'd86);
    assign disp_load = (state == S_SYS2 && cnt == 7'd86) || (state == S_DISPLAY && cnt <= 7'd97);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 12; i++) res[i] <= '0;
        end else if (sg_busy && sg_k == 2'd2 && sg_l == 2'd2) begin
            res[4'(sg_n)] <= sg_sum;
        end else if (s3_busy[2] && s3_l[2] == 2'd2) begin
            res[4'd4 + 4'(s3_n[2])] <= s3_fwd[2];
        end else if (s2_busy && s2_s == 3'd4) begin
            res[4'd8 + 4'(s2_n)] <= s2_sum0 + s2_acc1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)          display_result <= '0;
        else if (disp_load) display_result <= res[disp_idx][DW-1:0];
    end
endmodule

// File: tb/tb_conv3x3_engine_top.sv
// Directed bench for conv3x3_engine_top: state trace, result stream, input isolation and abort.
module tb_conv3x3_engine_top;
    logic       clk = 1'b0;
    logic       reset, run;
    logic [7:0] a_v [16];
    logic [7:0] b_v [9];
    logic [7:0] display_result;
    logic [2:0] display_current_state;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         last_disp = 0;

    always #5 clk = ~clk;

    conv3x3_engine_top dut (
        .clk(clk), .reset(reset), .run(run),
        .a11(a_v[0]),  .a12(a_v[1]),  .a13(a_v[2]),  .a14(a_v[3]),
        .a21(a_v[4]),  .a22(a_v[5]),  .a23(a_v[6]),  .a24(a_v[7]),
        .a31(a_v[8]),  .a32(a_v[9]),  .a33(a_v[10]), .a34(a_v[11]),
        .a41(a_v[12]), .a42(a_v[13]), .a43(a_v[14]), .a44(a_v[15]),
        .b11(b_v[0]), .b12(b_v[1]), .b13(b_v[2]),
        .b21(b_v[3]), .b22(b_v[4]), .b23(b_v[5]),
        .b31(b_v[6]), .b32(b_v[7]), .b33(b_v[8]),
        .display_result(display_result),
        .display_current_state(display_current_state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_scen2();
        a_v = '{8, 6, 10, 10, 9, 1, 10, 5, 1, 3, 1, 8, 10, 6, 10, 1};
        b_v = '{2, 5, 5, 5, 3, 5, 4, 0, 4};
    endtask

    function automatic int exp_state(input int k);
        if (k < 40)  return 1;
        if (k < 60)  return 2;
        if (k < 87)  return 3;
        if (k < 99)  return 4;
        if (k == 99) return 5;
        return 0;
    endfunction

    // mode 0: plain run; mode 1: scramble inputs and toggle run during SINGLE;
    // mode 2: assert reset at E0+50 and leave.
    task automatic run_scen(input string name, input int e0, input int e1,
                            input int e2, input int e3, input int mode);
        int exp_v [4];
        int idx;
        exp_v = '{e0, e1, e2, e3};
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        check($sformatf("%s state k=0", name), int'(display_current_state), 1);
        for (int k = 1; k <= 101; k++) begin
            if (mode == 1 && k >= 3 && k <= 20) begin
                a_v[k % 16] = 8'($urandom);
                b_v[k % 9]  = 8'($urandom);
                run = (k % 2 == 1) && (k < 20);
            end
            if (mode == 2 && k == 50) reset = 1'b1;
            @(posedge clk); #1;
            if (mode == 2 && k == 50) begin
                check($sformatf("%s abort state", name), int'(display_current_state), 0);
                check($sformatf("%s abort disp", name), int'(display_result), 0);
                reset = 1'b0;
                last_disp = 0;
                return;
            end
            check($sformatf("%s state k=%0d", name, k), int'(display_current_state), exp_state(k));
            if (k < 87) begin
                if (k % 20 == 0)
                    check($sformatf("%s hold k=%0d", name, k), int'(display_result), last_disp);
            end else begin
                idx = (k >= 98) ? 11 : k - 87;
                check($sformatf("%s disp k=%0d", name, k), int'(display_result), exp_v[idx % 4]);
            end
        end
        last_disp = e3;
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        for (int i = 0; i < 16; i++) a_v[i] = '0;
        for (int i = 0; i < 9; i++)  b_v[i] = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("idle state %0d", i), int'(display_current_state), 0);
            check($sformatf("idle disp %0d", i), int'(display_result), 0);
            @(posedge clk); #1;
        end

        set_scen2();
        run_scen("mix", 202, 216, 172, 163, 0);

        for (int i = 0; i < 16; i++) a_v[i] = 8'd255;
        for (int i = 0; i < 9; i++)  b_v[i] = 8'd255;
        run_scen("max", 9, 9, 9, 9, 0);

        for (int i = 0; i < 16; i++) a_v[i] = 8'(i + 1);
        b_v = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        run_scen("corner", 11, 12, 15, 16, 0);

        set_scen2();
        run_scen("isolate", 202, 216, 172, 163, 1);

        set_scen2();
        run_scen("abort", 202, 216, 172, 163, 2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post abort state %0d", i), int'(display_current_state), 0);
            check($sformatf("post abort disp %0d", i), int'(display_result), 0);
        end
        run_scen("rerun", 202, 216, 172, 163, 0);

        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("final hold %0d", i), int'(display_result), 163);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
